path_readback: RTL and testbench
================================

Name: path_readback

Overview:
- Avalon-MM slave that returns Dijkstra results to the HPS.
- It is the read direction of the host interface; the host-to-datapath write direction is handled elsewhere.
- The datapath pushes path nodes with their cumulative distance into an internal FIFO, then signals completion.
- Software polls STATUS or takes the interrupt, drains the FIFO via register reads, and clears the block for the next run.

Parameters:
- DEPTH, 64, FIFO entries; power of two, minimum 4.
- NODE_W, 8, node-id width.
- DIST_W, 16, per-node distance width.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- push_valid  in  1  datapath offers a path entry.
- push_node  in  NODE_W  node id.
- push_dist  in  DIST_W  cumulative distance to the node.
- push_ready  out  1  entry accepted when push_valid and push_ready are both high.
- path_done  in  1  one-cycle pulse: path complete.
- total_dist  in  DIST_W  final distance, sampled on path_done.
- chipselect  in  1  Avalon select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  3  word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, COMPLETE state.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty; state IDLE; overflow=0; total register=0.
  - readdata=0, irq=0, push_ready=1.
- Register map, read latency fixed at 1 cycle (readdata updates the cycle after chipselect&read; otherwise it holds):
  - addr 0 STATUS = {16'b0, count[7:0], 4'b0, overflow, complete, full, empty}. count saturates at 255 for DEPTH>255.
  - addr 1 POP: if not empty, returns {1'b1, 7'b0, node, dist} and pops the entry.
    - The layout shown is for the defaults. Generally: bit 31 = valid flag, dist in the low DIST_W bits, node in the next NODE_W bits.
  - addr 1 POP when empty: returns 32'h0000_0000 (valid=0); no pointer change.
  - addr 2 PEEK: same format as POP, no pop.
  - addr 3 TOTAL = zero-extended total_dist latched on path_done.
  - addr 4 on read returns 0.
  - addr 5–7 read 0.
  - Writes to any address except 4 are ignored.
  - A write to addr 4 with writedata[0]=1 is CLEAR: flush FIFO, overflow=0, TOTAL=0, state to IDLE, irq=0.
- FSM:
  - IDLE → COLLECT on the first accepted push.
  - IDLE or COLLECT → COMPLETE on path_done; a zero-length path (path_done from IDLE) is legal.
  - COMPLETE → IDLE on CLEAR, or when the last entry is popped.
  - path_done while already in COMPLETE: TOTAL is overwritten, state is unchanged.
- irq = (state==COMPLETE).
- push_ready = !full. This is combinational from registered occupancy, so it is valid in the same cycle.
- push_valid while full: entry dropped, overflow sets sticky (cleared only by CLEAR or reset).
- Simultaneous push and POP:
  - Not full, not empty: both occur, count unchanged.
  - Empty: POP returns valid=0 and the push is stored.
  - Full: the pop occurs, the push is rejected (push_ready was low), overflow sets.
- Same-cycle precedence:
  - CLEAR coinciding with push: CLEAR wins, the push is discarded.
  - CLEAR coinciding with path_done: CLEAR wins.
- Pointers are log2(DEPTH)+1 bits:
  - Wrap-around through the MSB; full when the MSBs differ and the rest match.
  - count = wr_ptr − rd_ptr, modulo.
- Reset asserted mid-drain: all state is lost; no partial readdata.

Decomposition:
- Package path_readback_pkg:
  - register address localparams: ADDR_STATUS=0, ADDR_POP=1, ADDR_PEEK=2, ADDR_TOTAL=3, ADDR_CTRL=4;
  - state enum rb_state_t {IDLE, COLLECT, COMPLETE};
  - STATUS bit-index constants.
- Sub-module path_fifo:
  - synchronous FIFO, parameterised width/depth;
  - ports push/pop/flush, empty/full/count, head data;
  - asynchronous active-low reset.
- Top level holds the FSM, the Avalon decode and the readdata register.

Test Plan:
- Reset, then read addr 0 → readdata 32'h0000_0001 (empty) one cycle after the read; irq=0.
- Push (3,10), (7,25), (9,40), pulse path_done with total_dist=40:
  - STATUS = 32'h0000_0304 (count 3, complete), irq=1;
  - TOTAL = 40;
  - POP ×3 → 32'h8003_000A, 32'h8007_0019, 32'h8009_0028; irq then drops.
- POP on empty FIFO → 32'h0000_0000; PEEK after one push of (5,1) → 32'h8005_0001 twice, count stays 1.
- Fill DEPTH=64 entries:
  - push_ready=0 and STATUS full=1;
  - a 65th push_valid sets overflow;
  - POP returns entry 0, not the dropped one;
  - after 64 pops, empty=1.
- Wrap-around: push 40, pop 40, push 50, pop 50 → data in order, count 0, no spurious full.
- Mid-operation events:
  - CLEAR write in the same cycle as push_valid → count 0, overflow 0, state IDLE;
  - asynchronous reset asserted mid-drain → readdata=0 and irq=0 immediately, empty=1 after release.

Source files
------------

// File: rtl/path_readback_pkg.sv
// Shared definitions for the path readback block: register map, FSM states,
// STATUS bit positions and the count saturation helper.
package path_readback_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_POP    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PEEK   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TOTAL  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd4;

  typedef enum logic [1:0] {IDLE, COLLECT, COMPLETE} rb_state_t;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COMPLETE  = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;

  function automatic logic [7:0] sat_count8(input logic [31:0] cnt);
    return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/path_readback_if.sv
// Datapath push port, completion strobe and Avalon-MM read/control port.
interface path_readback_if
  import path_readback_pkg::*;
#(
  parameter int NODE_W = 8,
  parameter int DIST_W = 16
);
  logic              push_valid;
  logic [NODE_W-1:0] push_node;
  logic [DIST_W-1:0] push_dist;
  logic              push_ready;
  logic              path_done;
  logic [DIST_W-1:0] total_dist;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  modport master (
    output push_valid, push_node, push_dist, path_done, total_dist,
           chipselect, read, write, address, writedata,
    input  push_ready, readdata, irq
  );

  modport slave (
    input  push_valid, push_node, push_dist, path_done, total_dist,
           chipselect, read, write, address, writedata,
    output push_ready, readdata, irq
  );
endinterface

// File: rtl/path_readback_fifo.sv
// Synchronous FIFO with extra-MSB pointers; flush takes priority over push/pop.
module path_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/path_readback.sv
// Avalon-MM read-back of Dijkstra path results: entry FIFO, run FSM, register decode.
module path_readback
  import path_readback_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int NODE_W = 8,
  parameter int DIST_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  path_readback_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = NODE_W + DIST_W;

  logic          rd_en, clear, pop_req, push_acc, pop_fire;
  logic          fifo_empty, fifo_full;
  logic [AW:0]   fifo_count;
  logic [EW-1:0] head;
  rb_state_t     state, state_nxt;
  logic          overflow;
  logic [DIST_W-1:0] total_q;
  logic [31:0]   readdata_q, rd_mux, entry_word, status_word;
  logic          unused_wdata;

  assign unused_wdata = ^bus.writedata[31:1];

  assign rd_en    = bus.chipselect & bus.read;
  assign clear    = bus.chipselect & bus.write & (bus.address == ADDR_CTRL) & bus.writedata[0];
  assign pop_req  = rd_en & (bus.address == ADDR_POP);
  assign push_acc = bus.push_valid & ~fifo_full & ~clear;
  assign pop_fire = pop_req & ~fifo_empty & ~clear;

  path_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_acc),
    .pop   (pop_fire),
    .flush (clear),
    .din   ({bus.push_node, bus.push_dist}),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bus.push_ready = ~fifo_full;

  always_comb begin
    entry_word = '0;
    if (!fifo_empty) begin
      entry_word[31]     = 1'b1;
      entry_word[EW-1:0] = head;
    end
  end

  always_comb begin
    status_word                     = '0;
    status_word[ST_EMPTY]           = fifo_empty;
    status_word[ST_FULL]            = fifo_full;
    status_word[ST_COMPLETE]        = (state == COMPLETE);
    status_word[ST_OVERFLOW]        = overflow;
    status_word[ST_COUNT_LSB +: 8]  = sat_count8(32'(fifo_count));
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_STATUS:         rd_mux = status_word;
      ADDR_POP, ADDR_PEEK: rd_mux = entry_word;
      ADDR_TOTAL:          rd_mux = 32'(total_q);
      default:             rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_q <= '0;
      overflow   <= 1'b0;
      total_q    <= '0;
    end else begin
      if (rd_en) readdata_q <= rd_mux;
      if (clear) begin
        overflow <= 1'b0;
        total_q  <= '0;
      end else begin
        if (bus.push_valid && fifo_full) overflow <= 1'b1;
        if (bus.path_done) total_q <= bus.total_dist;
      end
    end
  end

  assign bus.readdata = readdata_q;

  // state | meaning
  // IDLE     | no run in progress, FIFO empty or just cleared
  // COLLECT  | datapath is pushing path entries
  // COMPLETE | path finished, irq raised until drained or cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.path_done)  state_nxt = COMPLETE;
          else if (push_acc)  state_nxt = COLLECT;
        end
        COLLECT: begin
          if (bus.path_done)  state_nxt = COMPLETE;
        end
        COMPLETE: begin
          // A new path_done keeps the run complete even if the last entry leaves now.
          if (!bus.path_done && pop_fire && !push_acc &&
              fifo_count == (AW+1)'(1))
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.irq = (state == COMPLETE);
  end
endmodule

// File: tb/tb_path_readback.sv
// Directed scenarios followed by a randomized run against a queue-based model.
module tb_path_readback;
  import path_readback_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;

  path_readback_if #(.NODE_W(8), .DIST_W(16)) bus();

  path_readback #(.DEPTH(DEPTH), .NODE_W(8), .DIST_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [23:0] mq[$];
  bit          m_ovf;
  bit          m_cmp;
  logic [15:0] m_tot;
  logic [31:0] exp_hold;
  logic [31:0] d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] entry(input logic [7:0] n, input logic [15:0] ds);
    return {1'b1, 7'b0, n, ds};
  endfunction

  function automatic logic [31:0] status(input int cnt, input bit ovf, input bit cmp);
    logic [7:0] c8;
    c8 = (cnt > 255) ? 8'hFF : 8'(cnt);
    return {16'b0, c8, 4'b0, ovf, cmp, (cnt == DEPTH), (cnt == 0)};
  endfunction

  task automatic bus_idle();
    bus.push_valid = 0; bus.push_node = '0; bus.push_dist = '0;
    bus.path_done = 0; bus.total_dist = '0;
    bus.chipselect = 0; bus.read = 0; bus.write = 0;
    bus.address = '0; bus.writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] rd);
    bus.chipselect = 1; bus.read = 1; bus.address = a;
    @(negedge clk);
    bus.chipselect = 0; bus.read = 0;
    rd = bus.readdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
    bus.chipselect = 1; bus.write = 1; bus.address = a; bus.writedata = wd;
    @(negedge clk);
    bus.chipselect = 0; bus.write = 0; bus.writedata = '0;
  endtask

  task automatic push(input logic [7:0] n, input logic [15:0] ds);
    bus.push_valid = 1; bus.push_node = n; bus.push_dist = ds;
    @(negedge clk);
    bus.push_valid = 0;
  endtask

  task automatic done(input logic [15:0] t);
    bus.path_done = 1; bus.total_dist = t;
    @(negedge clk);
    bus.path_done = 0;
  endtask

  initial begin
    bus_idle();
    repeat (3) @(negedge clk);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", 32'(bus.irq), 32'h0);
    check("reset_push_ready", 32'(bus.push_ready), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    bus_read(ADDR_STATUS, d);
    check("status_after_reset", d, 32'h0000_0001);

    push(8'd3, 16'd10); push(8'd7, 16'd25); push(8'd9, 16'd40);
    done(16'd40);
    bus_read(ADDR_STATUS, d);
    check("status_complete", d, 32'h0000_0304);
    check("irq_complete", 32'(bus.irq), 32'h1);
    bus_read(ADDR_TOTAL, d);
    check("total", d, 32'd40);
    bus_read(ADDR_POP, d); check("pop0", d, 32'h8003_000A);
    bus_read(ADDR_POP, d); check("pop1", d, 32'h8007_0019);
    bus_read(ADDR_POP, d); check("pop2", d, 32'h8009_0028);
    check("irq_drained", 32'(bus.irq), 32'h0);

    bus_read(ADDR_POP, d);
    check("pop_empty", d, 32'h0);
    push(8'd5, 16'd1);
    bus_read(ADDR_PEEK, d); check("peek_a", d, 32'h8005_0001);
    bus_read(ADDR_PEEK, d); check("peek_b", d, 32'h8005_0001);
    bus_read(ADDR_STATUS, d); check("peek_count", d, 32'h0000_0100);
    bus_write(ADDR_CTRL, 32'h1);

    for (int i = 0; i < DEPTH; i++) push(8'(i + 1), 16'(i * 3 + 7));
    check("full_push_ready", 32'(bus.push_ready), 32'h0);
    bus_read(ADDR_STATUS, d); check("status_full", d, 32'h0000_4002);
    push(8'hEE, 16'hBEEF);
    bus_read(ADDR_STATUS, d); check("status_overflow", d, 32'h0000_400A);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(ADDR_POP, d);
      check($sformatf("fill_pop%0d", i), d, entry(8'(i + 1), 16'(i * 3 + 7)));
    end
    bus_read(ADDR_STATUS, d); check("status_drained_ovf", d, 32'h0000_0009);
    bus_write(ADDR_CTRL, 32'h1);
    bus_read(ADDR_STATUS, d); check("status_cleared", d, 32'h0000_0001);

    for (int i = 0; i < 40; i++) push(8'(i), 16'(1000 + i));
    for (int i = 0; i < 40; i++) begin
      bus_read(ADDR_POP, d); check("wrap_pop40", d, entry(8'(i), 16'(1000 + i)));
    end
    for (int i = 0; i < 50; i++) push(8'(100 + i), 16'(2000 + i));
    bus_read(ADDR_STATUS, d); check("wrap_status50", d, status(50, 0, 0));
    for (int i = 0; i < 50; i++) begin
      bus_read(ADDR_POP, d); check("wrap_pop50", d, entry(8'(100 + i), 16'(2000 + i)));
    end
    bus_read(ADDR_STATUS, d); check("wrap_status_end", d, 32'h0000_0001);

    push(8'd1, 16'd2); push(8'd3, 16'd4);
    done(16'd6);
    bus.push_valid = 1; bus.push_node = 8'h55; bus.push_dist = 16'h55;
    bus_write(ADDR_CTRL, 32'h1);
    bus.push_valid = 0;
    check("clear_push_irq", 32'(bus.irq), 32'h0);
    bus_read(ADDR_STATUS, d); check("clear_push_status", d, 32'h0000_0001);
    bus_read(ADDR_TOTAL, d); check("clear_total", d, 32'h0);

    // Randomized phase: model holds the entry queue, sticky flags and total.
    mq.delete(); m_ovf = 0; m_cmp = 0; m_tot = '0;
    bus_read(ADDR_STATUS, d); check("rand_start", d, 32'h0000_0001);
    exp_hold = 32'h0000_0001;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit pv, clr, rd, pd, was_full, popped;
      logic [7:0]  nn;
      logic [15:0] dd, tt;
      logic [2:0]  ad;
      int r;
      pv  = ($urandom_range(0, 99) < ((cyc / 150) % 2 == 0 ? 70 : 35));
      nn  = 8'($urandom); dd = 16'($urandom); tt = 16'($urandom);
      clr = ($urandom_range(0, 199) < 3);
      rd  = !clr && ($urandom_range(0, 99) < 55);
      r   = $urandom_range(0, 9);
      ad  = (r < 5) ? 3'd1 : 3'(r - 4);
      pd  = ($urandom_range(0, 99) < 3);
      bus.push_valid = pv; bus.push_node = nn; bus.push_dist = dd;
      bus.path_done = pd; bus.total_dist = tt;
      bus.chipselect = rd | clr; bus.read = rd; bus.write = clr;
      bus.address = clr ? ADDR_CTRL : ad;
      bus.writedata = clr ? 32'h1 : 32'h0;

      if (rd) begin
        case (ad)
          3'd0:       exp_hold = status(mq.size(), m_ovf, m_cmp);
          3'd1, 3'd2: exp_hold = (mq.size() > 0) ? {1'b1, 7'b0, mq[0]} : 32'h0;
          3'd3:       exp_hold = {16'b0, m_tot};
          default:    exp_hold = 32'h0;
        endcase
      end

      if (clr) begin
        mq.delete(); m_ovf = 0; m_cmp = 0; m_tot = '0;
      end else begin
        was_full = (mq.size() == DEPTH);
        popped = 0;
        if (rd && ad == 3'd1 && mq.size() > 0) begin
          void'(mq.pop_front());
          popped = 1;
        end
        if (pv && !was_full) mq.push_back({nn, dd});
        else if (pv) m_ovf = 1;
        if (pd) begin
          m_tot = tt;
          m_cmp = 1;
        end else if (m_cmp && popped && mq.size() == 0) begin
          m_cmp = 0;
        end
      end

      @(negedge clk);
      check("rand_readdata", bus.readdata, exp_hold);
      check("rand_irq", 32'(bus.irq), 32'(m_cmp));
      check("rand_push_ready", 32'(bus.push_ready), 32'(mq.size() < DEPTH));
    end
    bus_idle();
    bus_write(ADDR_CTRL, 32'h1);

    push(8'd11, 16'd12); push(8'd13, 16'd14); push(8'd15, 16'd16);
    done(16'd16);
    bus_read(ADDR_POP, d); check("drain_pop", d, 32'h800B_000C);
    #2 reset = 1'b0;
    #1;
    check("midreset_readdata", bus.readdata, 32'h0);
    check("midreset_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(ADDR_STATUS, d); check("post_reset_status", d, 32'h0000_0001);
    bus_read(ADDR_TOTAL, d); check("post_reset_total", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
